// File: rtl/apb_uart_host.sv
`default_nettype none
// ============================================================================
//  Module      : apb_uart_host
//  Description : APB3 initiator for the APB-UART register port. Turns one
//                valid/ready command into one APB transfer (SETUP, ACCESS),
//                honours PREADY wait states, captures PSLVERR and returns
//                the result on a valid/ready response channel.
//  Options     : `define APB_HOST_TIMEOUT_EN adds an ACCESS watchdog that
//                aborts after TIMEOUT_CYCLES wait states (rsp_error=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_uart_host #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy,
    // APB initiator port
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic                  r_busy;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;

`ifdef APB_HOST_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Count value seen on the last permitted wait-state edge.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [c_CNT_W-1:0]    r_wait_cnt;
`endif

    // Single transfer sequencer; every output is a register set on state entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_busy      <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
`ifdef APB_HOST_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    // cmd_ready is registered, so the first post-reset
                    // cycle never accepts a command.
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_psel      <= 1'b1;
                        r_pwrite    <= cmd_write;
                        r_paddr     <= cmd_addr;
                        r_pwdata    <= cmd_wdata;
                        r_state     <= ST_SETUP;
`ifdef APB_HOST_TIMEOUT_EN
                        r_wait_cnt  <= '0;
`endif
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready is checked first so completion beats the watchdog.
                    if (pready) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= pslverr;
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_state     <= ST_RESP;
                    end
`ifdef APB_HOST_TIMEOUT_EN
                    else if (r_wait_cnt == c_CNT_LAST) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + c_CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign busy      = r_busy;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_uart_host
//  Description : Self-checking bench for apb_uart_host. The bench plays the
//                APB responder and predicts each transfer at transaction
//                level: APB phase counts, response contents, handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_uart_host;

    localparam int c_AW = 8;
    localparam int c_DW = 32;
    localparam int c_TO = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_write = 1'b0;
    logic [c_AW-1:0] cmd_addr = '0;
    logic [c_DW-1:0] cmd_wdata = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [c_DW-1:0] rsp_rdata;
    logic            rsp_error;
    logic            busy;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [c_AW-1:0] paddr;
    logic [c_DW-1:0] pwdata;
    logic [c_DW-1:0] prdata = '0;
    logic            pready = 1'b0;
    logic            pslverr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    apb_uart_host #(
        .ADDR_WIDTH     (c_AW),
        .DATA_WIDTH     (c_DW),
        .TIMEOUT_CYCLES (c_TO)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .busy      (busy),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Wait (bounded) until the DUT offers cmd_ready; called at a negedge.
    task automatic wait_ready(input string tag);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        chk(tag, 64'(guard < 10), 64'(1));
    endtask

    // One transfer. waits = ACCESS cycles with pready low before it rises,
    // hold = cycles rsp_ready stays low while the response is presented.
    task automatic xfer(input logic wr, input logic [c_AW-1:0] a, input logic [c_DW-1:0] wd,
                        input int waits, input logic [c_DW-1:0] rd, input logic er,
                        input int hold);
        logic            aborted;
        int              n_acc;
        logic [c_DW-1:0] exp_rd;
        logic            exp_er;
`ifdef APB_HOST_TIMEOUT_EN
        aborted = (waits >= c_TO);
`else
        aborted = 1'b0;
`endif
        n_acc  = aborted ? c_TO : waits + 1;
        exp_rd = aborted ? '0 : (wr ? '0 : rd);
        exp_er = aborted ? 1'b1 : er;

        pready    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        wait_ready("accept_wait");
        @(negedge clock);
        // SETUP cycle. Keep cmd_valid high with junk: a busy host must ignore it.
        cmd_write = ~wr;
        cmd_addr  = c_AW'($urandom);
        cmd_wdata = $urandom;
        chk("setup_phase", 64'({psel, penable, pwrite, paddr, pwdata, busy, cmd_ready, rsp_valid}),
            64'({1'b1, 1'b0, wr, a, wd, 1'b1, 1'b0, 1'b0}));
        for (int i = 0; i < n_acc; i++) begin
            @(negedge clock);
            chk("access_phase", 64'({psel, penable, pwrite, paddr, pwdata, rsp_valid, cmd_ready}),
                64'({1'b1, 1'b1, wr, a, wd, 1'b0, 1'b0}));
            pready  = (i == waits);
            prdata  = (i == waits) ? rd : $urandom;
            pslverr = (i == waits) ? er : 1'($urandom);
        end
        @(negedge clock);
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = $urandom;
        chk("resp_present", 64'({rsp_valid, rsp_error, rsp_rdata, psel, penable, busy, cmd_ready}),
            64'({1'b1, exp_er, exp_rd, 1'b0, 1'b0, 1'b1, 1'b0}));
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("resp_hold", 64'({rsp_valid, rsp_error, rsp_rdata, psel, busy, cmd_ready}),
                64'({1'b1, exp_er, exp_rd, 1'b0, 1'b1, 1'b0}));
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        // Cycle after the handshake: idle, no psel yet even with cmd_valid high.
        chk("resp_done", 64'({rsp_valid, psel, penable, busy, cmd_ready}),
            64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
    endtask

    // Abandon a read stuck in ACCESS by asserting reset.
    task automatic reset_mid;
        pready    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        cmd_wdata = '0;
        wait_ready("mid_accept_wait");
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
`ifdef APB_HOST_TIMEOUT_EN
        @(negedge clock);
`else
        repeat (100) @(negedge clock);
`endif
        chk("stuck_access", 64'({psel, penable, rsp_valid}), 64'({1'b1, 1'b1, 1'b0}));
        reset = 1'b1;
        @(negedge clock);
        chk("mid_reset", 64'({psel, penable, rsp_valid, busy, cmd_ready}), 64'(0));
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_ready", 64'({cmd_ready, busy}), 64'({1'b1, 1'b0}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clock);
        chk("reset_outputs", 64'({cmd_ready, rsp_valid, rsp_error, rsp_rdata, busy, psel, penable, pwrite}),
            64'(0));
        chk("reset_apb_bus", 64'({paddr, pwdata}), 64'(0));
        reset = 1'b0;
        @(negedge clock);
        chk("first_ready", 64'({cmd_ready, busy}), 64'({1'b1, 1'b0}));

        // rsp_ready high while idle must not produce anything.
        rsp_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_rsp_ready", 64'({rsp_valid, busy, psel, cmd_ready}), 64'({1'b0, 1'b0, 1'b0, 1'b1}));
        rsp_ready = 1'b0;

        // Directed cases.
        xfer(1'b1, 8'h04, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 1'b0, 0);
        xfer(1'b0, 8'h08, 32'h0, 3, 32'h0000_003C, 1'b0, 0);
        xfer(1'b0, 8'h0C, 32'h0, 1, 32'h1234_5678, 1'b1, 5);
        // Back-to-back: the next call re-presents the command in the idle cycle.
        xfer(1'b1, 8'h00, 32'h0000_0055, 0, 32'h0, 1'b0, 0);
        xfer(1'b0, 8'h14, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 0);

        reset_mid();
        xfer(1'b1, 8'h04, 32'h0000_005A, 0, 32'h0, 1'b0, 0);

`ifdef APB_HOST_TIMEOUT_EN
        // pready on the limit cycle completes normally; beyond it aborts.
        xfer(1'b0, 8'h18, 32'h0, c_TO - 1, 32'h0000_0077, 1'b0, 0);
        xfer(1'b0, 8'h1C, 32'h0, c_TO + 2, 32'h0000_0099, 1'b0, 1);
`endif

        // Randomized transfers.
        for (int n = 0; n < 40; n++) begin
            xfer(1'($urandom), c_AW'($urandom), $urandom, int'($urandom_range(0, 5)),
                 $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
